// File: rtl/fpu_collect_pkg.sv
// Shared types and constants for the FPU result collector.
// Holds the IEEE status bit layout, the canonical quiet NaN and the
// default-width entry struct buffered by the collector FIFO.
package fpu_collect_pkg;

    // IEEE exception flag positions inside a status word
    localparam int STAT_NV = 4;
    localparam int STAT_DZ = 3;
    localparam int STAT_OF = 2;
    localparam int STAT_UF = 1;
    localparam int STAT_NX = 0;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    typedef logic [4:0] status_t;

    // Entry layout at the default widths (FP32 result, 1-bit tag)
    typedef struct packed {
        logic [31:0] result;
        status_t     status;
        logic [0:0]  tag;
    } fpu_entry_t;

    // FP32 NaN: exponent all ones with a non-zero mantissa
    function automatic logic is_nan32(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'h000000);
    endfunction

endpackage

// File: rtl/fpu_collect_fifo.sv
// Generic synchronous FIFO with occupancy counter and synchronous flush.
// The read side shows the head entry straight from storage registers and
// reads all-zero while empty. Writing is refused while full, even when the
// head is popped in the same cycle.
module fpu_collect_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   wr_valid_i,
    input  entry_t wr_data_i,
    output logic   wr_ready_o,
    output entry_t rd_data_o,
    output logic   rd_valid_o,
    input  logic   rd_ready_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    entry_t        mem_q [DEPTH];

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;

    assign full_s     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_s    = (cnt_q == '0);
    assign push_s     = wr_valid_i & ~full_s;
    assign pop_s      = rd_ready_i & ~empty_s;
    assign wr_ready_o = ~full_s;
    assign rd_valid_o = ~empty_s;

    // Head entry from storage; forced to zero when nothing is buffered
    always_comb begin
        if (empty_s) begin
            rd_data_o = '0;
        end else begin
            rd_data_o = mem_q[rd_ptr_q];
        end
    end

    // Pointer and occupancy next-state; flush wins over any handshake
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; a push coinciding with flush is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fpu_result_collector.sv
// FPU result collector: buffers the FPU result/status/tag stream in a
// small FIFO, replays it to a consumer, and keeps sticky exception flags
// plus a saturating count of accepted results.
// Optional build macro FPU_COLLECT_NAN_CANON_EN: NaN results are stored
// as the canonical quiet NaN instead of bit-exact.
module fpu_result_collector
    import fpu_collect_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 1,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     res_i,
    input  status_t              status_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [WIDTH-1:0]     res_o,
    output status_t              status_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    input  logic                 clear_flags_i,
    output status_t              fflags_o,
    output logic [CNT_WIDTH-1:0] res_cnt_o,
    output logic                 busy_o
);

    typedef struct packed {
        logic [WIDTH-1:0]     result;
        status_t              status;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t               wr_entry_s;
    entry_t               rd_entry_s;
    logic                 push_s;
    status_t              push_status_s;
    status_t              fflags_q, fflags_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign push_s = in_valid_i & in_ready_o;

    // Build the entry to store, canonicalising NaNs when enabled
    always_comb begin
        wr_entry_s.status = status_i;
        wr_entry_s.tag    = tag_i;
`ifdef FPU_COLLECT_NAN_CANON_EN
        if (is_nan32(32'(res_i))) begin
            wr_entry_s.result = WIDTH'(CANON_QNAN);
        end else begin
            wr_entry_s.result = res_i;
        end
`else
        wr_entry_s.result = res_i;
`endif
    end

    fpu_collect_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .wr_valid_i (in_valid_i),
        .wr_data_i  (wr_entry_s),
        .wr_ready_o (in_ready_o),
        .rd_data_o  (rd_entry_s),
        .rd_valid_o (out_valid_o),
        .rd_ready_i (out_ready_i)
    );

    assign res_o    = rd_entry_s.result;
    assign status_o = rd_entry_s.status;
    assign tag_o    = rd_entry_s.tag;
    assign busy_o   = out_valid_o;

    // Sticky flag and saturating counter next-state; flushed pushes still count
    always_comb begin
        if (push_s) begin
            push_status_s = status_i;
        end else begin
            push_status_s = 5'b00000;
        end
        if (clear_flags_i) begin
            fflags_d = push_status_s;
        end else begin
            fflags_d = fflags_q | push_status_s;
        end
        if (push_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Flag and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fflags_q <= 5'b00000;
            cnt_q    <= '0;
        end else begin
            fflags_q <= fflags_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fflags_o  = fflags_q;
    assign res_cnt_o = cnt_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench for fpu_result_collector: directed scenarios followed
// by randomized traffic, compared against a queue-based reference model.
// A narrow counter is used so that saturation is reachable.
module tb_fpu_result_collector;

    localparam int WIDTH     = 32;
    localparam int TAG_WIDTH = 1;
    localparam int DEPTH     = 4;
    localparam int CNT_WIDTH = 4;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk;
    logic                 rst_i;
    logic                 flush_i;
    logic [WIDTH-1:0]     res_i;
    logic [4:0]           status_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     res_o;
    logic [4:0]           status_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 clear_flags_i;
    logic [4:0]           fflags_o;
    logic [CNT_WIDTH-1:0] res_cnt_o;
    logic                 busy_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [37:0] mq[$];
    logic [4:0]  m_flags;
    int          m_cnt;

    fpu_result_collector #(
        .WIDTH     (WIDTH),
        .TAG_WIDTH (TAG_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .res_i         (res_i),
        .status_i      (status_i),
        .tag_i         (tag_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .res_o         (res_o),
        .status_o      (status_o),
        .tag_o         (tag_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .clear_flags_i (clear_flags_i),
        .fflags_o      (fflags_o),
        .res_cnt_o     (res_cnt_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_store(input logic [31:0] r);
`ifdef FPU_COLLECT_NAN_CANON_EN
        if (r[30:23] == 8'hFF && r[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_flags = 5'b00000;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        logic [37:0] head;
        head = (mq.size() != 0) ? mq[0] : 38'd0;
        check_eq("out_valid", out_valid_o, mq.size() != 0);
        check_eq("busy",      busy_o,      mq.size() != 0);
        check_eq("in_ready",  in_ready_o,  mq.size() < DEPTH);
        check_eq("res",       res_o,       head[37:6]);
        check_eq("status",    status_o,    head[5:1]);
        check_eq("tag",       tag_o,       head[0]);
        check_eq("fflags",    fflags_o,    m_flags);
        check_eq("res_cnt",   res_cnt_o,   m_cnt);
    endtask

    // one clock: check current outputs, apply inputs, advance model
    task automatic step(input logic iv, input logic [31:0] r, input logic [4:0] st,
                        input logic t, input logic ordy, input logic fl, input logic cl);
        logic push, pop;
        check_outputs();
        in_valid_i    = iv;
        res_i         = r;
        status_i      = st;
        tag_i         = t;
        out_ready_i   = ordy;
        flush_i       = fl;
        clear_flags_i = cl;
        @(posedge clk);
        push = iv && (mq.size() < DEPTH);
        pop  = ordy && (mq.size() != 0);
        m_flags = (cl ? 5'b00000 : m_flags) | (push ? st : 5'b00000);
        if (push && m_cnt < CNT_MAX) m_cnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({model_store(r), st, t});
        end
        @(negedge clk);
        in_valid_i    = 1'b0;
        flush_i       = 1'b0;
        clear_flags_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; res_i = 32'd0; status_i = 5'd0; tag_i = 1'b0;
        in_valid_i = 1'b0; out_ready_i = 1'b0; clear_flags_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check_eq("rst_in_ready", in_ready_o, 1'b1);

        // single push of 3.0
        step(1'b1, 32'h4040_0000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("tp1_valid", out_valid_o, 1'b1);
        check_eq("tp1_res", res_o, 32'h4040_0000);
        check_eq("tp1_cnt", res_cnt_o, 4'd1);
        check_eq("tp1_flags", fflags_o, 5'b00000);
        step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // fill with consumer stalled; fifth push refused
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h3F80_0000 + i, 5'd0, i[0], 1'b0, 1'b0, 1'b0);
            if (i == 3) check_eq("full_ready", in_ready_o, 1'b0);
        end
        check_eq("full_head", res_o, 32'h3F80_0000);
        step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ready_after_pop", in_ready_o, 1'b1);
        check_eq("second_head", res_o, 32'h3F80_0001);
        repeat (3) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // sticky flags and clear
        step(1'b1, 32'h4000_0000, 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h4100_0000, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("flags_or", fflags_o, 5'b00101);
        step(1'b1, 32'h4200_0000, 5'b10000, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("flags_clear", fflags_o, 5'b10000);
        repeat (2) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // flush with a simultaneous push
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h4400_0000 + i, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h4500_0000, 5'b01000, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("flush_valid", out_valid_o, 1'b0);
        check_eq("flush_cnt", res_cnt_o, 4'd4);
        check_eq("flush_flags", fflags_o, 5'b01000);

        // NaN storage
        step(1'b1, 32'hFF80_0001, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FPU_COLLECT_NAN_CANON_EN
        check_eq("nan_store", res_o, 32'h7FC0_0000);
`else
        check_eq("nan_store", res_o, 32'hFF80_0001);
`endif
        step(1'b1, 32'h4600_0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset between edges with two entries held
        check_eq("pre_rst_valid", out_valid_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("arst_valid", out_valid_o, 1'b0);
        check_eq("arst_busy", busy_o, 1'b0);
        check_eq("arst_flags", fflags_o, 5'b00000);
        check_eq("arst_cnt", res_cnt_o, 4'd0);
        check_eq("arst_ready", in_ready_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 5) == 0) r[30:23] = 8'hFF;
            step($urandom_range(0, 3) != 0, r, 5'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 15) == 0);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Downstream stage of the FP32 FPU top. Consumes the FPU result/status/tag stream through a valid/ready handshake and buffers results in a small FIFO.
- Replays the buffered results to a consumer (bench checker or writeback) through a second valid/ready port.
- Keeps sticky IEEE exception flags (fflags-style) and a count of accepted results.
- Drives the FPU out_ready, so backpressure propagates into the FPU pipeline.

Parameters:
- WIDTH, 32, result width in bits (FP32).
- TAG_WIDTH, 1, width of the operation tag carried with each result.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the accepted-result counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous FIFO flush.
- res_i  in  WIDTH  FPU result.
- status_i  in  5  FPU status {NV,DZ,OF,UF,NX}, package status type.
- tag_i  in  TAG_WIDTH  FPU result tag.
- in_valid_i  in  1  FPU output valid.
- in_ready_o  out  1  ready to FPU (drives FPU out_ready).
- res_o  out  WIDTH  buffered result, FIFO head.
- status_o  out  5  status of the head entry.
- tag_o  out  TAG_WIDTH  tag of the head entry.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer ready.
- clear_flags_i  in  1  synchronous clear of sticky flags.
- fflags_o  out  5  sticky OR of the status of all accepted results.
- res_cnt_o  out  CNT_WIDTH  number of accepted results, saturating.
- busy_o  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (rst_i high, asynchronous): FIFO empty, read/write pointers 0, fflags_o=0, res_cnt_o=0, out_valid_o=0, busy_o=0, in_ready_o=1. res_o/status_o/tag_o read 0 while empty.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = !full, driven combinationally from registered occupancy only (no path from out_ready_i). There is no same-cycle bypass when full: a pop while full does not allow a push in that cycle.
- Storage: a registered FIFO with occupancy counter 0..DEPTH. Pointers wrap modulo DEPTH.
- Latency: an entry pushed in cycle N is visible on res_o with out_valid_o=1 in cycle N+1. There is no combinational input-to-output path.
- Simultaneous push and pop when not full and not empty: occupancy unchanged and both pointers advance.
- Ordering is strictly FIFO. A head entry is held stable, with out_valid_o=1, until it is popped.
- Sticky flags, next value:
  - clear_flags_i=1: next = (push ? status_i : 0).
  - otherwise: next = fflags_o | (push ? status_i : 0).
- Counter: res_cnt_o increments on every push and saturates at 2^CNT_WIDTH-1. flush_i and clear_flags_i do not affect it.
- flush_i: next cycle occupancy=0, pointers=0, out_valid_o=0. A push in the flush cycle is discarded but still counted and still ORed into the flags. A pop in the flush cycle is ignored.
- busy_o = (occupancy != 0).
- Reset asserted mid-transfer: all state returns to reset values immediately; any in-flight handshake is lost.

Optional Feature:
- Macro FPU_COLLECT_NAN_CANON_EN.
- Defined: on push, any NaN result (exponent all ones, mantissa non-zero) is stored as canonical quiet NaN 32'h7FC0_0000. Status and tag are stored unchanged.
- Undefined: the result is stored bit-exact. No extra logic.

Decomposition:
- Shared package (fpu_collect_pkg):
  - status bit indices NV=4, DZ=3, OF=2, UF=1, NX=0;
  - CANON_QNAN = 32'h7FC0_0000;
  - a packed entry struct {result, status, tag}.
- One sub-module: fpu_collect_fifo, a generic synchronous FIFO (DEPTH, entry type, flush) holding the packed entry.
- Flags, counter and NaN canonicalisation stay in the top module.

Test Plan:
- Reset, then push res 32'h4040_0000 (3.0) with status 0 while out_ready_i=1 -> in the next cycle out_valid_o=1, res_o=32'h4040_0000, res_cnt_o=1, fflags_o=0.
- out_ready_i=0, push 5 results -> after 4 pushes in_ready_o=0 and the 5th is not accepted; raise out_ready_i -> results drain in order and in_ready_o returns to 1 the cycle after the first pop.
- Push status 5'b00001 (NX), then 5'b00100 (OF) -> fflags_o=5'b00101. clear_flags_i together with a push of status 5'b10000 -> fflags_o=5'b10000.
- Fill 3 entries, then assert flush_i with a push in the same cycle -> out_valid_o=0 the next cycle, res_cnt_o=4, flags include the flushed push's status.
- With FPU_COLLECT_NAN_CANON_EN, push 32'hFF80_0001 -> res_o=32'h7FC0_0000. Without the macro -> res_o=32'hFF80_0001.
- Assert rst_i asynchronously between clock edges with 2 entries held -> out_valid_o, busy_o, fflags_o and res_cnt_o all go to 0 before the next edge.
